// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Issues fetch requests over a req/gnt + rvalid handshake and keeps its own PC queue
// so each returning word is paired with the address that fetched it. Responses land in
// a small buffer behind a single output slot that ID consumes. Branch and flush squash
// all younger work; in-flight responses from before a squash are counted and discarded.
// Credit rule: buffered + outstanding never exceeds FIFO_DEPTH. The buffer therefore
// always has room for every response still in flight.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        stall_if,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          IW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic          fetch_en;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop;

    logic [31:0]   pcq [FIFO_DEPTH];
    logic [IW-1:0] pcq_rd;
    logic [IW-1:0] pcq_wr;

    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [IW-1:0] buf_rd;
    logic [IW-1:0] buf_wr;
    logic [CW-1:0] buf_count;

    logic          accept;
    logic          keep;
    logic          squash;
    logic          slot_free;
    logic          buf_empty;
    logic          buf_pop;
    logic          bypass;
    logic          buf_push;
    logic [CW:0]   inflight;
    logic [31:0]   rsp_pc;
    logic          unused_target_lsbs;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        if (p == IW'(FIFO_DEPTH - 1))
            return '0;
        else
            return p + IW'(1);
    endfunction

    // Request side and response classification, all derived from current state.
    assign inflight           = {1'b0, buf_count} + {1'b0, outstanding};
    assign imem_req           = fetch_en & (inflight < DEPTH_C);
    assign imem_addr          = fetch_pc;
    assign accept             = imem_req & imem_gnt;
    assign keep               = imem_rvalid & (drop == '0);
    assign squash             = branch | flush;
    assign rsp_pc             = pcq[pcq_rd];
    assign slot_free          = ~valid | ~stall_if;
    assign buf_empty          = (buf_count == '0);
    assign buf_pop            = slot_free & ~buf_empty;
    assign bypass             = slot_free & buf_empty & keep;
    assign buf_push           = keep & ~bypass;
    assign unused_target_lsbs = ^branch_target[1:0];

    // Outstanding count: requests accepted minus responses returned, squashed ones included.
    always_comb begin
        outstanding_nxt = outstanding;
        case ({accept, imem_rvalid})
            2'b10:   outstanding_nxt = outstanding + CW'(1);
            2'b01:   outstanding_nxt = outstanding - CW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // Fetch address and fetch enable: branch redirects, flush halts, accept advances.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            fetch_pc <= RESET_PC;
            fetch_en <= 1'b1;
        end else if (branch) begin
            fetch_pc <= {branch_target[31:2], 2'b00};
            fetch_en <= 1'b1;
        end else if (flush) begin
            fetch_en <= 1'b0;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Outstanding and drop counters; on squash everything still in flight becomes droppable.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (squash)
                drop <= outstanding_nxt;
            else if (imem_rvalid && drop != '0)
                drop <= drop - CW'(1);
        end
    end

    // PC queue storage: address of every accepted request, in issue order.
    always_ff @(posedge clk) begin
        if (accept)
            pcq[pcq_wr] <= fetch_pc;
    end

    // PC queue pointers; only kept responses consume an entry.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            pcq_rd <= '0;
            pcq_wr <= '0;
        end else if (squash) begin
            pcq_rd <= '0;
            pcq_wr <= '0;
        end else begin
            if (accept)
                pcq_wr <= ptr_inc(pcq_wr);
            if (keep)
                pcq_rd <= ptr_inc(pcq_rd);
        end
    end

    // Response buffer storage for kept responses the slot cannot take this cycle.
    always_ff @(posedge clk) begin
        if (buf_push) begin
            buf_pc[buf_wr]    <= rsp_pc;
            buf_instr[buf_wr] <= imem_rdata;
        end
    end

    // Response buffer pointers and occupancy.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            buf_rd    <= '0;
            buf_wr    <= '0;
            buf_count <= '0;
        end else if (squash) begin
            buf_rd    <= '0;
            buf_wr    <= '0;
            buf_count <= '0;
        end else begin
            if (buf_push)
                buf_wr <= ptr_inc(buf_wr);
            if (buf_pop)
                buf_rd <= ptr_inc(buf_rd);
            case ({buf_push, buf_pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Output slot to ID: buffer head first, then a same-cycle response, else empty.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (slot_free) begin
            if (!buf_empty) begin
                valid <= 1'b1;
                pc    <= buf_pc[buf_rd];
                instr <= buf_instr[buf_rd];
            end else if (keep) begin
                valid <= 1'b1;
                pc    <= rsp_pc;
                instr <= imem_rdata;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule
